traffic_source: RTL and testbench

//  Parametrised NoC traffic generator: injects flits into a router local port over a
//  two-phase (toggle) req/ack link. Successor of the single-destination source:

---
 rtl/traffic_source.sv | 152 +++++++++++++++
 tb/tb_traffic_source.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_source.sv
// NoC traffic generator driving a router local port over a two-phase req/ack link.
// Optional ack watchdog enabled by defining SOURCE_ACK_TIMEOUT_EN.
module traffic_source #(
    parameter int ID        = 0,
    parameter int DEST      = 0,
    parameter int DEST_MODE = 0,
    parameter int NUM_DEST  = 4,
    parameter int DEST_W    = 4,
    parameter int ID_W      = 4,
    parameter int DATA_W    = 16,
    parameter int MAX_FLITS = 2,
    parameter int GAP       = 0,
    parameter int TIMEOUT   = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              ack,
    output logic              req,
    output logic [DATA_W-1:0] data,
    output logic [15:0]       flit_count,
    output logic              done,
    output logic              err
);

    localparam int SEQ_W = (DATA_W > DEST_W + ID_W) ? DATA_W - DEST_W - ID_W : 1;
    localparam int RR_W  = (NUM_DEST > 1) ? $clog2(NUM_DEST) : 1;
    localparam logic [RR_W-1:0] RR_LAST   = RR_W'(NUM_DEST - 1);
    localparam logic [15:0]     LFSR_SEED = 16'hACE1 ^ 16'(ID);
    localparam logic [15:0]     DEST_MASK = 16'(NUM_DEST - 1);
    localparam logic [15:0]     MAX_F     = 16'(MAX_FLITS);
    localparam logic [15:0]     GAP_LOAD  = 16'(GAP - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_GAP, S_DONE} state_t;

    state_t            state_reg;
    logic              req_reg;
    logic [DATA_W-1:0] data_reg;
    logic [15:0]       flit_count_reg;
    logic              done_reg;
    logic              err_reg;
    logic              ack_old_reg;
    logic [SEQ_W-1:0]  seq_reg;
    logic [RR_W-1:0]   rr_reg;
    logic [15:0]       lfsr_reg;
    logic [15:0]       gap_cnt_reg;
`ifdef SOURCE_ACK_TIMEOUT_EN
    logic [15:0]       wait_cnt_reg;
    localparam logic [15:0] TIMEOUT_M1 = 16'(TIMEOUT - 1);
`endif

    logic                          ack_rx;
    logic                          can_launch;
    logic                          lfsr_fb;
    logic [DEST_W-1:0]             dest_cur;
    logic [SEQ_W+ID_W+DEST_W-1:0]  flit_wide;

    assign ack_rx     = ack ^ ack_old_reg;
    assign can_launch = (MAX_FLITS == 0) || (flit_count_reg < MAX_F);
    // Fibonacci taps for x^16+x^14+x^13+x^11+1, shifting toward bit 0
    assign lfsr_fb    = lfsr_reg[0] ^ lfsr_reg[2] ^ lfsr_reg[3] ^ lfsr_reg[5];
    assign flit_wide  = {seq_reg, ID_W'(ID), dest_cur};

    always_comb begin
        case (DEST_MODE)
            1:       dest_cur = DEST_W'(rr_reg);
            2:       dest_cur = DEST_W'(lfsr_reg & DEST_MASK);
            default: dest_cur = DEST_W'(DEST);
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg      <= S_IDLE;
            req_reg        <= 1'b0;
            data_reg       <= '0;
            flit_count_reg <= '0;
            done_reg       <= 1'b0;
            err_reg        <= 1'b0;
            ack_old_reg    <= 1'b0;
            seq_reg        <= '0;
            rr_reg         <= '0;
            lfsr_reg       <= LFSR_SEED;
            gap_cnt_reg    <= '0;
`ifdef SOURCE_ACK_TIMEOUT_EN
            wait_cnt_reg   <= '0;
`endif
        end else begin
            ack_old_reg <= ack;
            case (state_reg)
                S_IDLE: begin
                    if (ack_rx)
                        err_reg <= 1'b1;
                    if (en && can_launch) begin
                        data_reg <= flit_wide[DATA_W-1:0];
                        req_reg  <= ~req_reg;
                        if (flit_count_reg != 16'hFFFF)
                            flit_count_reg <= flit_count_reg + 16'd1;
                        seq_reg  <= seq_reg + 1'b1;
                        rr_reg   <= (rr_reg == RR_LAST) ? '0 : rr_reg + 1'b1;
                        lfsr_reg <= {lfsr_fb, lfsr_reg[15:1]};
`ifdef SOURCE_ACK_TIMEOUT_EN
                        wait_cnt_reg <= '0;
`endif
                        state_reg <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (ack_rx) begin
                        if (MAX_FLITS != 0 && flit_count_reg == MAX_F) begin
                            done_reg  <= 1'b1;
                            state_reg <= S_DONE;
                        end else if (GAP == 0) begin
                            state_reg <= S_IDLE;
                        end else begin
                            gap_cnt_reg <= GAP_LOAD;
                            state_reg   <= S_GAP;
                        end
                    end
`ifdef SOURCE_ACK_TIMEOUT_EN
                    else begin
                        if (wait_cnt_reg != 16'hFFFF)
                            wait_cnt_reg <= wait_cnt_reg + 16'd1;
                        if (wait_cnt_reg == TIMEOUT_M1)
                            err_reg <= 1'b1;
                    end
`endif
                end
                S_GAP: begin
                    if (ack_rx)
                        err_reg <= 1'b1;
                    if (gap_cnt_reg == 16'd0)
                        state_reg <= S_IDLE;
                    else
                        gap_cnt_reg <= gap_cnt_reg - 16'd1;
                end
                S_DONE: begin
                    if (ack_rx)
                        err_reg <= 1'b1;
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign req        = req_reg;
    assign data       = data_reg;
    assign flit_count = flit_count_reg;
    assign done       = done_reg;
    assign err        = err_reg;

endmodule

// File: tb/tb_traffic_source.sv
// Self-checking bench for traffic_source: fixed, round-robin and LFSR destination
// instances driven by a randomized two-phase sink and checked against a flit model.
module tb_traffic_source;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // fixed destination instance
    logic        f_reset, f_en, f_ack, f_req, f_done, f_err;
    logic [15:0] f_data, f_cnt;
    // round-robin instance with inter-flit gap
    logic        r_reset, r_en, r_ack, r_req, r_done, r_err;
    logic [15:0] r_data, r_cnt;
    // LFSR instance, unlimited flits
    logic        l_reset, l_en, l_ack, l_req, l_done, l_err;
    logic [15:0] l_data, l_cnt;

    traffic_source #(.ID(1), .DEST(3), .DEST_MODE(0), .MAX_FLITS(2), .GAP(0)) u_fix (
        .clk(clk), .reset(f_reset), .en(f_en), .ack(f_ack), .req(f_req),
        .data(f_data), .flit_count(f_cnt), .done(f_done), .err(f_err));

    traffic_source #(.ID(2), .DEST_MODE(1), .NUM_DEST(4), .MAX_FLITS(6), .GAP(3)) u_rr (
        .clk(clk), .reset(r_reset), .en(r_en), .ack(r_ack), .req(r_req),
        .data(r_data), .flit_count(r_cnt), .done(r_done), .err(r_err));

    traffic_source #(.ID(5), .DEST_MODE(2), .NUM_DEST(4), .MAX_FLITS(0), .GAP(0)) u_lf (
        .clk(clk), .reset(l_reset), .en(l_en), .ack(l_ack), .req(l_req),
        .data(l_data), .flit_count(l_cnt), .done(l_done), .err(l_err));

    // Flit n: seq n in bits [15:8], source id in [7:4], destination in [3:0]
    function automatic logic [15:0] exp_flit(input int id, input int dest, input int seq);
        return 16'(((seq % 256) << 8) + (id << 4) + dest);
    endfunction

    // Destination of the n-th flit from the LFSR source: seed stepped n times
    function automatic int lfsr_dest(input int id, input int n);
        logic [15:0] s;
        s = 16'hACE1 ^ 16'(id);
        for (int k = 0; k < n; k++)
            s = {s[16-16] ^ s[16-14] ^ s[16-13] ^ s[16-11], s[15:1]};
        return int'(s) % 4;
    endfunction

    function automatic logic get_req(input int which);
        case (which)
            0:       return f_req;
            1:       return r_req;
            default: return l_req;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Cycles until req toggles; -1 if it never does within limit
    task automatic wait_req(input int which, input int limit, output int cyc);
        logic prev;
        prev = get_req(which);
        cyc  = 0;
        do begin
            tick();
            cyc++;
        end while (get_req(which) == prev && cyc < limit);
        if (get_req(which) == prev)
            cyc = -1;
    endtask

    task automatic test_reset();
        f_reset = 0; r_reset = 0; l_reset = 0;
        f_en = 0; r_en = 0; l_en = 0;
        f_ack = 0; r_ack = 0; l_ack = 0;
        repeat (3) tick();
        n_tests++;
        if ({f_req, f_data, f_cnt, f_done, f_err} !== 35'd0) begin
            n_fail++;
            $display("FAIL reset_fix: got %h expected 0", {f_req, f_data, f_cnt, f_done, f_err});
        end
        n_tests++;
        if ({r_req, r_data, r_cnt, r_done, r_err} !== 35'd0) begin
            n_fail++;
            $display("FAIL reset_rr: got %h expected 0", {r_req, r_data, r_cnt, r_done, r_err});
        end
        n_tests++;
        if ({l_req, l_data, l_cnt, l_done, l_err} !== 35'd0) begin
            n_fail++;
            $display("FAIL reset_lfsr: got %h expected 0", {l_req, l_data, l_cnt, l_done, l_err});
        end
        f_reset = 1; r_reset = 1; l_reset = 1;
        tick();
        $display("[TB] reset checked");
    endtask

    task automatic test_fixed();
        int cyc;
        f_en = 1;
        for (int i = 0; i < 2; i++) begin
            wait_req(0, 10, cyc);
            n_tests++;
            if (cyc != ((i == 0) ? 1 : 2)) begin
                n_fail++;
                $display("FAIL fix_latency[%0d]: got %0d expected %0d", i, cyc, (i == 0) ? 1 : 2);
            end
            n_tests++;
            if (f_data !== exp_flit(1, 3, i)) begin
                n_fail++;
                $display("FAIL fix_data[%0d]: got %h expected %h", i, f_data, exp_flit(1, 3, i));
            end
            $display("[TB] fixed flit %0d data=%h", i, f_data);
            tick();
            f_ack = ~f_ack;
        end
        repeat (3) tick();
        n_tests++;
        if ({f_done, f_cnt, f_err} !== {1'b1, 16'd2, 1'b0}) begin
            n_fail++;
            $display("FAIL fix_status: got done=%b cnt=%0d err=%b expected done=1 cnt=2 err=0",
                     f_done, f_cnt, f_err);
        end
        wait_req(0, 10, cyc);
        n_tests++;
        if (cyc != -1) begin
            n_fail++;
            $display("FAIL fix_no_extra: got toggle after %0d cycles expected none", cyc);
        end
    endtask

    task automatic test_round_robin_gap();
        int cyc;
        int d;
        r_en = 1;
        for (int i = 0; i < 6; i++) begin
            wait_req(1, 20, cyc);
            n_tests++;
            if (cyc != ((i == 0) ? 1 : 5)) begin
                n_fail++;
                $display("FAIL rr_gap_latency[%0d]: got %0d expected %0d", i, cyc, (i == 0) ? 1 : 5);
            end
            n_tests++;
            if (r_data !== exp_flit(2, i % 4, i)) begin
                n_fail++;
                $display("FAIL rr_data[%0d]: got %h expected %h", i, r_data, exp_flit(2, i % 4, i));
            end
            $display("[TB] rr flit %0d data=%h latency=%0d", i, r_data, cyc);
            d = $urandom_range(0, 3);
            repeat (d) tick();
            r_ack = ~r_ack;
        end
        repeat (3) tick();
        n_tests++;
        if ({r_done, r_cnt, r_err} !== {1'b1, 16'd6, 1'b0}) begin
            n_fail++;
            $display("FAIL rr_status: got done=%b cnt=%0d err=%b expected done=1 cnt=6 err=0",
                     r_done, r_cnt, r_err);
        end
    endtask

    task automatic test_enable();
        int cyc;
        int d;
        int m;
        int expc;
        n_tests++;
        if ({l_req, l_cnt} !== 17'd0) begin
            n_fail++;
            $display("FAIL en_blocked: got req=%b cnt=%0d expected req=0 cnt=0", l_req, l_cnt);
        end
        l_en = 1;
        wait_req(2, 5, cyc);
        n_tests++;
        if (cyc != 1) begin
            n_fail++;
            $display("FAIL en_first_latency: got %0d expected 1", cyc);
        end
        n_tests++;
        if (l_data !== exp_flit(5, lfsr_dest(5, 0), 0)) begin
            n_fail++;
            $display("FAIL lfsr_data[0]: got %h expected %h", l_data, exp_flit(5, lfsr_dest(5, 0), 0));
        end
        l_en  = 0;
        l_ack = ~l_ack;
        repeat (10) tick();
        n_tests++;
        if ({l_req, l_cnt, l_err} !== {1'b1, 16'd1, 1'b0}) begin
            n_fail++;
            $display("FAIL en_drop_wait: got req=%b cnt=%0d err=%b expected req=1 cnt=1 err=0",
                     l_req, l_cnt, l_err);
        end
        l_en = 1;
        for (int n = 1; n < 26; n++) begin
            wait_req(2, 20, cyc);
            expc = 1;
            if (n > 1) expc = 2;
            n_tests++;
            if (n == 1 || cyc != -1) begin
                if (cyc != expc && !(n > 1 && cyc == 1)) begin
                    n_fail++;
                    $display("FAIL lfsr_latency[%0d]: got %0d expected %0d", n, cyc, expc);
                end
            end else begin
                n_fail++;
                $display("FAIL lfsr_timeout[%0d]: got no toggle expected toggle", n);
            end
            n_tests++;
            if (l_data !== exp_flit(5, lfsr_dest(5, n), n)) begin
                n_fail++;
                $display("FAIL lfsr_data[%0d]: got %h expected %h", n, l_data,
                         exp_flit(5, lfsr_dest(5, n), n));
            end
            $display("[TB] lfsr flit %0d data=%h", n, l_data);
            d = $urandom_range(0, 2);
            repeat (d) tick();
            l_ack = ~l_ack;
            if ($urandom_range(0, 1) == 1) begin
                l_en = 0;
                m = $urandom_range(2, 6);
                repeat (m) tick();
                n_tests++;
                if (l_cnt !== 16'(n + 1)) begin
                    n_fail++;
                    $display("FAIL en_gate[%0d]: got cnt=%0d expected %0d", n, l_cnt, n + 1);
                end
                l_en = 1;
            end
        end
        wait_req(2, 20, cyc);
        tick();
        n_tests++;
        if ({l_cnt, l_err, l_done} !== {16'd27, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL lfsr_status: got cnt=%0d err=%b done=%b expected cnt=27 err=0 done=0",
                     l_cnt, l_err, l_done);
        end
    endtask

    task automatic test_spurious_and_reset();
        int cyc;
        r_reset = 0; r_en = 0; r_ack = 0;
        tick();
        n_tests++;
        if ({r_req, r_data, r_cnt, r_done, r_err} !== 35'd0) begin
            n_fail++;
            $display("FAIL rr_rereset: got %h expected 0", {r_req, r_data, r_cnt, r_done, r_err});
        end
        r_reset = 1;
        r_en    = 1;
        wait_req(1, 5, cyc);
        n_tests++;
        if (cyc != 1 || r_data !== exp_flit(2, 0, 0)) begin
            n_fail++;
            $display("FAIL sp_first: got cyc=%0d data=%h expected cyc=1 data=%h", cyc, r_data, exp_flit(2, 0, 0));
        end
        r_ack = ~r_ack;
        repeat (2) tick();
        r_ack = ~r_ack;
        tick();
        n_tests++;
        if (r_err !== 1'b1) begin
            n_fail++;
            $display("FAIL sp_err: got %b expected 1", r_err);
        end
        wait_req(1, 10, cyc);
        n_tests++;
        if (cyc != 2 || r_data !== exp_flit(2, 1, 1)) begin
            n_fail++;
            $display("FAIL sp_flow: got cyc=%0d data=%h expected cyc=2 data=%h", cyc, r_data, exp_flit(2, 1, 1));
        end
        r_reset = 0;
        r_ack   = 0;
        #1;
        n_tests++;
        if ({r_req, r_data, r_cnt, r_done, r_err} !== 35'd0) begin
            n_fail++;
            $display("FAIL async_reset: got %h expected 0", {r_req, r_data, r_cnt, r_done, r_err});
        end
        tick();
        r_reset = 1;
        wait_req(1, 5, cyc);
        n_tests++;
        if (cyc != 1 || r_data !== exp_flit(2, 0, 0)) begin
            n_fail++;
            $display("FAIL restart: got cyc=%0d data=%h expected cyc=1 data=%h", cyc, r_data, exp_flit(2, 0, 0));
        end
        $display("[TB] spurious ack and async reset checked");
    endtask

`ifdef SOURCE_ACK_TIMEOUT_EN
    task automatic test_timeout();
        int cyc;
        f_reset = 0; f_en = 0; f_ack = 0;
        tick();
        f_reset = 1;
        f_en    = 1;
        wait_req(0, 5, cyc);
        repeat (63) tick();
        n_tests++;
        if (f_err !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_early: got err=%b expected 0", f_err);
        end
        tick();
        n_tests++;
        if ({f_err, f_req} !== 2'b11) begin
            n_fail++;
            $display("FAIL timeout_err: got err=%b req=%b expected err=1 req=1", f_err, f_req);
        end
        f_ack = ~f_ack;
        wait_req(0, 10, cyc);
        n_tests++;
        if (cyc != 2 || f_data !== exp_flit(1, 3, 1)) begin
            n_fail++;
            $display("FAIL timeout_late_ack: got cyc=%0d data=%h expected cyc=2 data=%h", cyc, f_data, exp_flit(1, 3, 1));
        end
    endtask
`endif

    initial begin
        test_reset();
        test_fixed();
        test_round_robin_gap();
        test_enable();
        test_spurious_and_reset();
`ifdef SOURCE_ACK_TIMEOUT_EN
        test_timeout();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
